// File: rtl/alu_pkg.sv
// Shared ALU opcode and execution-state definitions, used by both the control-unit
// decoder and alu_exec_unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_OR  = 4'd3,
    ALU_AND = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7,
    ALU_DIV = 4'd8,
    ALU_NA  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int unsigned ALU_OP_W = 4;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiplier (shift-add) and restoring divider; one step per clock,
// WIDTH steps per operation. done/result show the final step before it is registered.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_r;
  logic             div_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] a_nx_s;
  logic [WIDTH-1:0] b_nx_s;
  logic [WIDTH:0]   acc_nx_s;
  logic [WIDTH:0]   rem_sh_s;

  // One iteration step; for DIV a_r holds dividend bits shifting out and quotient bits shifting in
  always_comb begin
    rem_sh_s = {acc_r[WIDTH-1:0], a_r[WIDTH-1]};
    a_nx_s   = a_r;
    b_nx_s   = b_r;
    acc_nx_s = acc_r;
    if (div_r) begin
      // divisor 0 never borrows, so the quotient saturates to all ones
      if (rem_sh_s >= {1'b0, b_r}) begin
        acc_nx_s = rem_sh_s - {1'b0, b_r};
        a_nx_s   = {a_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = rem_sh_s;
        a_nx_s   = {a_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (b_r[0]) begin
        acc_nx_s = acc_r + {1'b0, a_r};
      end else begin
        acc_nx_s = acc_r;
      end
      a_nx_s = {a_r[WIDTH-2:0], 1'b0};
      b_nx_s = {1'b0, b_r[WIDTH-1:1]};
    end
  end

  assign done   = busy_r && (cnt_r == LAST);
  assign result = div_r ? a_nx_s : acc_nx_s[WIDTH-1:0];

  // Operand load on start, then iterate until the last step is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      div_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      acc_r  <= {(WIDTH+1){1'b0}};
    end else if (start) begin
      busy_r <= 1'b1;
      div_r  <= is_div;
      cnt_r  <= {CW{1'b0}};
      a_r    <= opa;
      b_r    <= opb;
      acc_r  <= {(WIDTH+1){1'b0}};
    end else if (busy_r) begin
      a_r   <= a_nx_s;
      b_r   <= b_nx_s;
      acc_r <= acc_nx_s;
      if (done) begin
        busy_r <= 1'b0;
        cnt_r  <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle ops plus optional iterative MUL/DIV, enabled by
// defining macro ALU_EXEC_MULDIV_EN (otherwise codes 7 and 8 report illegal).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_r;
  logic             ready_r;
  logic             done_r;
  logic             zero_r;
  logic             illegal_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] alu_res_s;
  logic             illegal_s;
  logic             muldiv_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s = SrcB[SHW-1:0];

  // Single-cycle result and op classification from the live request inputs
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    illegal_s = 1'b0;
    muldiv_s  = 1'b0;
    case (alu_op_e'(ALUOp))
      ALU_ADD: alu_res_s = SrcA + SrcB;
      ALU_SUB: alu_res_s = SrcA - SrcB;
      ALU_XOR: alu_res_s = SrcA ^ SrcB;
      ALU_OR:  alu_res_s = SrcA | SrcB;
      ALU_AND: alu_res_s = SrcA & SrcB;
      ALU_SLL: alu_res_s = SrcA << shamt_s;
      ALU_SRL: alu_res_s = SrcA >> shamt_s;
`ifdef ALU_EXEC_MULDIV_EN
      ALU_MUL, ALU_DIV: muldiv_s = is_muldiv(ALUOp);
`endif
      default: illegal_s = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MULDIV_EN
  logic             md_start_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_result_s;

  assign md_start_s = (state_r == ST_IDLE) && start && muldiv_s;

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .is_div (ALUOp == ALU_DIV),
    .opa    (SrcA),
    .opb    (SrcB),
    .done   (md_done_s),
    .result (md_result_s)
  );
`endif

  // Control FSM; result flags change only when entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b1;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            ready_r <= 1'b0;
            if (muldiv_s) begin
              state_r <= ST_ITER;
            end else begin
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              result_r  <= alu_res_s;
              zero_r    <= (alu_res_s == {WIDTH{1'b0}});
              illegal_r <= illegal_s;
            end
          end
        end
`ifdef ALU_EXEC_MULDIV_EN
        ST_ITER: begin
          if (md_done_s) begin
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
            result_r  <= md_result_s;
            zero_r    <= (md_result_s == {WIDTH{1'b0}});
            illegal_r <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign ALUResult = result_r;
  assign Zero      = zero_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model expectations, monitor pops on done.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   ALUOp;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         ready;
  logic         done;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         illegal;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           acc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ALUOp     (ALUOp),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ready     (ready),
    .done      (done),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model straight from the operation definitions
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output int lat);
    logic [63:0] p;
    r = '0; ill = 1'b0; lat = 1; p = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a ^ b;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a << (b % W);
      4'd6: r = a >> (b % W);
`ifdef ALU_EXEC_MULDIV_EN
      4'd7: begin p = 64'(a) * 64'(b); r = p[W-1:0]; lat = W + 1; end
      4'd8: begin r = (b == 0) ? {W{1'b1}} : a / b; lat = W + 1; end
`endif
      default: begin r = '0; ill = 1'b1; end
    endcase
  endfunction

  // Drives one request once ready; returns at the negedge after the accept edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    exp_t e;
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'd0, ready}, 64'd1);
    model(op, a, b, e.res, e.ill, e.lat);
    e.acc = cyc + 1;
    lat = e.lat;
    ALUOp = op; SrcA = a; SrcB = b; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: done=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(ALUResult), 64'(e.res));
        chk("zero", {63'd0, Zero}, {63'd0, e.res == '0});
        chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_result"}, 64'(ALUResult), 64'd0);
    chk({tag, "_zero"}, {63'd0, Zero}, 64'd1);
    chk({tag, "_illegal"}, {63'd0, illegal}, 64'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [3:0] op;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; ALUOp = 4'd0; SrcA = '0; SrcB = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    issue(4'd0, 32'd5, 32'hFFFF_FFFB, lat);
    issue(4'd6, 32'h8000_0000, 32'h0000_0021, lat);
    issue(4'd5, 32'h0000_0003, 32'h0000_001F, lat);
    issue(4'd1, 32'd0, 32'd1, lat);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    issue(4'd7, 32'h0001_0000, 32'h0001_0001, lat);
    if (lat > 10) begin
      repeat (9) @(negedge clk);
      ALUOp = 4'd0; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
      chk("iter_ready", {63'd0, ready}, 64'd0);
      @(negedge clk);
      start = 1'b0;
    end
    issue(4'd8, 32'd100, 32'd7, lat);
    issue(4'd8, 32'd5, 32'd0, lat);
    issue(4'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF, lat);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, lat);

    // Reset 12 cycles into a DIV: the aborted request must never complete
    issue(4'd8, 32'd1000, 32'd3, lat);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_reset_state("abort");
    rst = 1'b0;
    issue(4'd0, 32'd2, 32'd3, lat);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      issue(op, a, b, lat);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have start  input  1  request; sampled only when ready=1.
REQ-005 SHALL have ALUOp  input  4  operation code, same encoding as the control-unit ALU decoder output.
REQ-006 SHALL have SrcA  input  WIDTH  first operand.
REQ-007 SHALL have SrcB  input  WIDTH  second operand; shift amount taken from SrcB[log2(WIDTH)-1:0].
REQ-008 SHALL have ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have done  output  1  single-cycle pulse; result valid.
REQ-010 SHALL have ALUResult  output  WIDTH  registered result, held until next accept.
REQ-011 SHALL have Zero  output  1  registered, equals (ALUResult == 0).
REQ-012 SHALL have illegal  output  1  registered, asserted with done for an unsupported ALUOp.

Function
REQ-013 SHALL accept a request on a rising edge where start=1 and ready=1, capturing ALUOp, SrcA and SrcB.
REQ-014 SHALL implement states IDLE, ITER and DONE: IDLE goes to DONE on accept of a single-cycle op; IDLE goes to ITER on accept of MUL or DIV; ITER goes to DONE after WIDTH iterations; DONE returns to IDLE unconditionally.
REQ-015 SHALL drive ready=1 only in IDLE and done=1 only in DONE.
REQ-016 SHALL ignore start while in ITER or DONE, with no queuing.
REQ-017 SHALL execute codes 0-6 (ADD, SUB, XOR, OR, AND, SLL, SRL) in one cycle, with done asserted on the cycle after accept.
REQ-018 SHALL compute ADD and SUB modulo 2^WIDTH; SRL is logical; carry and overflow are discarded.
REQ-019 SHALL compute MUL (7) by iterative shift-add, returning the low WIDTH bits of the unsigned product.
REQ-020 SHALL compute DIV (8) by iterative restoring division, returning the unsigned quotient.
REQ-021 SHALL return all ones on DIV with SrcB=0, after the full iteration count and with illegal=0.
REQ-022 SHALL assert done for MUL and DIV exactly WIDTH+1 cycles after accept, using an iteration counter of log2(WIDTH)+1 bits.
REQ-023 SHALL treat codes 9-15 as illegal: DONE next cycle, ALUResult=0, Zero=1, illegal=1.
REQ-024 SHALL update ALUResult, Zero and illegal only on the transition into DONE, keeping them stable through IDLE.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, counter 0, ready=1, done=0, ALUResult=0, Zero=1 and illegal=0.
REQ-026 SHALL abort any in-flight ITER on reset without ever producing a done pulse for the aborted request.
REQ-027 SHALL accept a new request on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, when macro ALU_EXEC_MULDIV_EN is defined, include the iterative MUL/DIV datapath and the ITER state.
REQ-029 SHALL, when ALU_EXEC_MULDIV_EN is undefined, handle codes 7 and 8 as illegal per REQ-023, with no ITER state or counter synthesized.

Structure
REQ-030 SHALL take ALUOp codes (ALU_ADD=0 through ALU_DIV=8, ALU_NA=15) and the state encoding from shared package alu_pkg, which the decoder also uses.
REQ-031 SHALL place the iterative multiplier/divider in sub-module alu_muldiv_seq, with a start/done interface and a WIDTH parameter.

Verification
REQ-032 SHALL check: ADD with SrcA=5, SrcB=0xFFFFFFFB -> done on cycle 1, ALUResult=0, Zero=1.
REQ-033 SHALL check: SRL with SrcA=0x80000000, SrcB=0x21 -> ALUResult=0x40000000 (shift 1), illegal=0.
REQ-034 SHALL check: MUL with 0x10000 x 0x10001 -> done on cycle 33, ALUResult=0x00010000; a start asserted at cycle 10 is ignored.
REQ-035 SHALL check: DIV with 100/7 -> 14 on cycle 33; DIV with 5/0 -> 0xFFFFFFFF, illegal=0.
REQ-036 SHALL check: ALUOp=15 -> illegal=1, ALUResult=0 on cycle 1; with the macro undefined, ALUOp=7 behaves identically.
REQ-037 SHALL check: rst pulsed at cycle 12 of a DIV -> no done, ready=1, and a following ADD 2+3 yields 5.
